// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and the per-axis region encoding.
package vga_timing_pkg;

    localparam int CNT_W      = 10;

    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int H_DISP_DEF = 640;
    localparam int H_FP_DEF   = 16;

    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;
    localparam int V_DISP_DEF = 480;
    localparam int V_FP_DEF   = 10;

    localparam int H_TOTAL = H_SYNC_DEF + H_BP_DEF + H_DISP_DEF + H_FP_DEF;
    localparam int V_TOTAL = V_SYNC_DEF + V_BP_DEF + V_DISP_DEF + V_FP_DEF;

    typedef enum logic [1:0] {
        SYNC,
        BACK_PORCH,
        ACTIVE,
        FRONT_PORCH
    } region_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus region/offset decoded from the
// next count, so a parent register stage lines up with the registered count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC = 96,
    parameter int BP   = 48,
    parameter int DISP = 640,
    parameter int FP   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output region_e          region,
    output logic [CNT_W-1:0] offset
);

    localparam int               TOTAL  = SYNC + BP + DISP + FP;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] BP_LO  = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_LO = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] FP_LO  = CNT_W'(SYNC + BP + DISP);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // region and offset describe count_d, i.e. the value count_q takes next cycle
    always_comb begin
        wrap    = adv && (count_q == LAST);
        count_d = count_q;
        if (adv) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end

        region = vga_timing_pkg::SYNC;
        offset = '0;
        if (count_d >= FP_LO) begin
            region = FRONT_PORCH;
        end else if (count_d >= ACT_LO) begin
            region = ACTIVE;
            offset = count_d - ACT_LO;
        end else if (count_d >= BP_LO) begin
            region = BACK_PORCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing transmitter: H/V counters, active-low syncs, display window with
// column/row, and line/frame start pulses, all registered and mutually aligned.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int H_DISP = H_DISP_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter int V_DISP = V_DISP_DEF,
    parameter int V_FP   = V_FP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] H_Counts,
    output logic [CNT_W-1:0] V_Counts,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             display,
    output logic [CNT_W-1:0] Display_Col,
    output logic [CNT_W-1:0] Display_Row,
    output logic             line_start,
    output logic             frame_start
);

    logic             h_wrap, v_wrap, v_adv;
    region_e          h_region, v_region;
    logic [CNT_W-1:0] h_offset, v_offset;

    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic             display_d, display_q;
    logic [CNT_W-1:0] col_d, col_q;
    logic [CNT_W-1:0] row_d, row_q;
    logic             line_start_d, line_start_q;
    logic             frame_start_d, frame_start_q;

    assign v_adv = pix_en & h_wrap;

    vga_axis_counter #(
        .SYNC(H_SYNC), .BP(H_BP), .DISP(H_DISP), .FP(H_FP)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (pix_en),
        .count  (H_Counts),
        .wrap   (h_wrap),
        .region (h_region),
        .offset (h_offset)
    );

    vga_axis_counter #(
        .SYNC(V_SYNC), .BP(V_BP), .DISP(V_DISP), .FP(V_FP)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (v_adv),
        .count  (V_Counts),
        .wrap   (v_wrap),
        .region (v_region),
        .offset (v_offset)
    );

    // Regions are next-count decodes, so these registers align with H_Counts/V_Counts
    always_comb begin
        hsync_d       = (h_region != SYNC);
        vsync_d       = (v_region != SYNC);
        display_d     = (h_region == ACTIVE) && (v_region == ACTIVE);
        col_d         = display_d ? h_offset : '0;
        row_d         = display_d ? v_offset : '0;
        line_start_d  = h_wrap;
        frame_start_d = h_wrap & v_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            display_q     <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_q     <= display_d;
            col_q         <= col_d;
            row_q         <= row_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign display     = display_q;
    assign Display_Col = col_q;
    assign Display_Row = row_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 timing and a tiny 8x4 timing run side by side
// from shared clk/reset/pix_en, each compared every cycle against a reference model.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;

    logic [9:0] d_h, d_v, d_col, d_row;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] s_h, s_v, s_col, s_row;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] h, v, col, row;
        logic       hs, vs, de, ls, fs;
    } exp_t;

    exp_t q_def[$];
    exp_t q_sm[$];

    // model timing: index 0 = default, index 1 = small
    int hs_p[2] = '{96, 2};
    int hb_p[2] = '{48, 2};
    int hd_p[2] = '{640, 8};
    int hf_p[2] = '{16, 2};
    int vs_p[2] = '{2, 1};
    int vb_p[2] = '{33, 1};
    int vd_p[2] = '{480, 4};
    int vf_p[2] = '{10, 1};
    int mh[2] = '{0, 0};
    int mv[2] = '{0, 0};

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .H_Counts(d_h), .V_Counts(d_v), .HSYNC(d_hs), .VSYNC(d_vs),
        .display(d_de), .Display_Col(d_col), .Display_Row(d_row),
        .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BP(2), .H_DISP(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_DISP(4), .V_FP(1)
    ) dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .H_Counts(s_h), .V_Counts(s_v), .HSYNC(s_hs), .VSYNC(s_vs),
        .display(s_de), .Display_Col(s_col), .Display_Row(s_row),
        .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_step(input int k, input bit rst, input bit pe);
        exp_t e;
        int   ht, vt, ha, va;
        bit   ls, fs;
        ht = hs_p[k] + hb_p[k] + hd_p[k] + hf_p[k];
        vt = vs_p[k] + vb_p[k] + vd_p[k] + vf_p[k];
        ha = hs_p[k] + hb_p[k];
        va = vs_p[k] + vb_p[k];
        ls = 1'b0;
        fs = 1'b0;
        if (rst) begin
            mh[k] = 0;
            mv[k] = 0;
        end else if (pe) begin
            ls = (mh[k] == ht - 1);
            fs = ls && (mv[k] == vt - 1);
            mh[k] = ls ? 0 : mh[k] + 1;
            if (ls) mv[k] = (mv[k] == vt - 1) ? 0 : mv[k] + 1;
        end
        e.h   = 10'(mh[k]);
        e.v   = 10'(mv[k]);
        e.hs  = (mh[k] >= hs_p[k]);
        e.vs  = (mv[k] >= vs_p[k]);
        e.de  = (mh[k] >= ha) && (mh[k] < ha + hd_p[k]) &&
                (mv[k] >= va) && (mv[k] < va + vd_p[k]);
        e.col = e.de ? 10'(mh[k] - ha) : 10'd0;
        e.row = e.de ? 10'(mv[k] - va) : 10'd0;
        e.ls  = ls;
        e.fs  = fs;
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        e = q_def.pop_front();
        chk("def_h", d_h, e.h);      chk("def_v", d_v, e.v);
        chk("def_hsync", d_hs, e.hs); chk("def_vsync", d_vs, e.vs);
        chk("def_display", d_de, e.de);
        chk("def_col", d_col, e.col); chk("def_row", d_row, e.row);
        chk("def_line_start", d_ls, e.ls); chk("def_frame_start", d_fs, e.fs);
        e = q_sm.pop_front();
        chk("sm_h", s_h, e.h);       chk("sm_v", s_v, e.v);
        chk("sm_hsync", s_hs, e.hs);  chk("sm_vsync", s_vs, e.vs);
        chk("sm_display", s_de, e.de);
        chk("sm_col", s_col, e.col);  chk("sm_row", s_row, e.row);
        chk("sm_line_start", s_ls, e.ls); chk("sm_frame_start", s_fs, e.fs);
    endtask

    task automatic step(input bit rst, input bit pe);
        @(negedge clk);
        reset  = rst;
        pix_en = pe;
        q_def.push_back(model_step(0, rst, pe));
        q_sm.push_back(model_step(1, rst, pe));
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int ls_cnt;

    initial begin
        // reset held 3 clocks with pix_en high, then 5 advances
        repeat (3) step(1'b1, 1'b1);
        chk("reset_h", d_h, 0);
        chk("reset_display", d_de, 0);
        repeat (5) step(1'b0, 1'b1);
        chk("h_after_5", d_h, 5);

        // alternating pix_en across a line wrap; line_start must last one clk
        ls_cnt = 0;
        for (int i = 0; i < 1700; i++) begin
            step(1'b0, (i % 2) == 0);
            if (d_ls) ls_cnt++;
        end
        chk("toggle_line_starts", ls_cnt, 1);

        // free run into the active region of the default timing
        for (int i = 0; i < 40000 && !(mh[0] == 500 && mv[0] == 36); i++)
            step(1'b0, 1'b1);
        chk("pre_reset_h", d_h, 500);
        chk("pre_reset_v", d_v, 36);

        // mid-frame reset
        step(1'b1, 1'b1);
        chk("midrst_h", d_h, 0);
        chk("midrst_v", d_v, 0);
        chk("midrst_hsync", d_hs, 0);
        chk("midrst_frame_start", d_fs, 0);

        // several small frames, then random pix_en gating
        repeat (320) step(1'b0, 1'b1);
        repeat (400) step(1'b0, 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
